// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI master APB register front-end:
// register offsets (PADDR[5:2]), the configuration struct and the stall FSM states.
package spi_apb_pkg;

  localparam logic [3:0] OFS_STATUS = 4'h0;
  localparam logic [3:0] OFS_CLKDIV = 4'h1;
  localparam logic [3:0] OFS_CMD    = 4'h2;
  localparam logic [3:0] OFS_ADDR   = 4'h3;
  localparam logic [3:0] OFS_LEN    = 4'h4;
  localparam logic [3:0] OFS_DUM    = 4'h5;
  localparam logic [3:0] OFS_TXFIFO = 4'h6;
  localparam logic [3:0] OFS_RXFIFO = 4'h8;
  localparam logic [3:0] OFS_INTCFG = 4'h9;
  localparam logic [3:0] OFS_INTSTA = 4'hA;

  typedef struct packed {
    logic [7:0]  csreg;
    logic [7:0]  clk_div;
    logic        clk_div_valid;
    logic [31:0] spi_cmd;
    logic [31:0] spi_addr;
    logic [15:0] data_len;
    logic [5:0]  addr_len;
    logic [5:0]  cmd_len;
    logic [15:0] dummy_wr;
    logic [15:0] dummy_rd;
  } spi_cfg_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } apb_state_e;

  // Bits below num_cs are implemented chip selects
  function automatic logic [7:0] cs_mask(input int num_cs);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (i < num_cs);
    return m;
  endfunction

endpackage

// File: rtl/spi_apb_irq.sv
// Sticky interrupt status (level/edge set, write-1-to-clear) and the registered,
// masked interrupt line of the SPI master APB front-end.
module spi_apb_irq
  import spi_apb_pkg::*;
#(
  parameter int LVL_W = 6
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [LVL_W-1:0] tx_lvl_i,
  input  logic [LVL_W-1:0] rx_lvl_i,
  input  logic [7:0]       th_tx,
  input  logic [7:0]       th_rx,
  input  logic             eot_i,
  input  logic [2:0]       int_en,
  input  logic             clr_en,
  input  logic [2:0]       clr_mask,
  output logic [2:0]       intsta,
  output logic             irq_o
);

  localparam int CW = (LVL_W > 8) ? LVL_W : 8;

  logic [2:0] intsta_r;
  logic       irq_r;
  logic [2:0] set_s;
  logic [2:0] clr_s;

  assign set_s = {eot_i, (CW'(rx_lvl_i) >= CW'(th_rx)), (CW'(tx_lvl_i) <= CW'(th_tx))};
  assign clr_s = clr_en ? clr_mask : 3'b000;

  // Status bits are sticky; a set in the same cycle as a clear keeps the bit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      intsta_r <= 3'b000;
      irq_r    <= 1'b0;
    end else begin
      intsta_r <= (intsta_r & ~clr_s) | set_s;
      irq_r    <= |(intsta_r & int_en);
    end
  end

  assign intsta = intsta_r;
  assign irq_o  = irq_r;

endmodule

// File: rtl/spi_master_apb_regif.sv
// APB register front-end for the quad SPI master: register decode, FIFO stall FSM, PSLVERR.
// Optional build macro SPI_APB_TIMEOUT_EN bounds FIFO stalls to TIMEOUT_CYCLES.
module spi_master_apb_regif
  import spi_apb_pkg::*;
#(
  parameter  int APB_ADDR_WIDTH   = 12,
  parameter  int BUFFER_DEPTH     = 32,
  parameter  int NUM_CS           = 4,
  parameter  int TIMEOUT_CYCLES   = 16,
  localparam int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output spi_cfg_t                  cfg_o,
  output logic [4:0]                cmd_o,
  input  logic [31:0]               status_i,
  input  logic [LOG_BUFFER_DEPTH:0] tx_lvl_i,
  input  logic [LOG_BUFFER_DEPTH:0] rx_lvl_i,
  input  logic                      eot_i,
  output logic [31:0]               tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  input  logic [31:0]               rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic                      irq_o
);

  localparam logic [7:0] CS_MASK = cs_mask(NUM_CS);

  spi_cfg_t   cfg_r;
  logic [4:0] cmd_r;
  logic [2:0] int_en_r;
  logic [7:0] th_rx_r;
  logic [7:0] th_tx_r;
  logic [2:0] intsta_s;
  apb_state_e state_r;

  logic [3:0] addr_s;
  logic       access_s, map_s, bad_dir_s, dec_err_s;
  logic       tx_acc_s, rx_acc_s, fifo_acc_s, fifo_rdy_s;
  logic       timeout_s, complete_s, reg_wr_s, unused_s;

  assign addr_s   = PADDR[5:2];
  assign unused_s = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};
  assign access_s = PSEL & PENABLE;

  // Address map decode
  always_comb begin
    map_s = 1'b0;
    case (addr_s)
      OFS_STATUS, OFS_CLKDIV, OFS_CMD, OFS_ADDR, OFS_LEN, OFS_DUM,
      OFS_TXFIFO, OFS_RXFIFO, OFS_INTCFG, OFS_INTSTA: map_s = 1'b1;
      default: map_s = 1'b0;
    endcase
  end

  assign bad_dir_s  = ((addr_s == OFS_TXFIFO) & ~PWRITE) | ((addr_s == OFS_RXFIFO) & PWRITE);
  assign dec_err_s  = access_s & (~map_s | bad_dir_s);
  assign tx_acc_s   = access_s & PWRITE & (addr_s == OFS_TXFIFO);
  assign rx_acc_s   = access_s & ~PWRITE & (addr_s == OFS_RXFIFO);
  assign fifo_acc_s = tx_acc_s | rx_acc_s;
  assign fifo_rdy_s = tx_acc_s ? tx_ready_i : rx_valid_i;
  assign complete_s = fifo_rdy_s & ~timeout_s;

  // The handshake completes in the very cycle the FIFO becomes ready, so these stay combinational
  assign PREADY     = fifo_acc_s ? (fifo_rdy_s | timeout_s) : 1'b1;
  assign PSLVERR    = dec_err_s | timeout_s;
  assign tx_valid_o = tx_acc_s & complete_s;
  assign rx_ready_o = rx_acc_s & complete_s;
  assign tx_data_o  = PWDATA;
  assign reg_wr_s   = access_s & PWRITE & ~dec_err_s & (addr_s != OFS_TXFIFO);

  // Stall tracker: leaves STALL on ready, timeout or an abandoned transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fifo_acc_s && !fifo_rdy_s) state_r <= ST_STALL;
          else                           state_r <= ST_IDLE;
        end
        ST_STALL: begin
          if (!fifo_acc_s || fifo_rdy_s || timeout_s) state_r <= ST_IDLE;
          else                                        state_r <= ST_STALL;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_r;

  // Counts wait-state cycles of the current FIFO transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stall_cnt_r <= '0;
    end else if (fifo_acc_s && !fifo_rdy_s && !timeout_s) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ST_STALL) & fifo_acc_s & (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // Register writes; clk_div_valid and the command pulses last one cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cfg_r    <= '0;
      cmd_r    <= 5'b00000;
      int_en_r <= 3'b000;
      th_rx_r  <= 8'h00;
      th_tx_r  <= 8'h00;
    end else begin
      cfg_r.clk_div_valid <= 1'b0;
      cmd_r               <= 5'b00000;
      if (reg_wr_s) begin
        case (addr_s)
          OFS_STATUS: begin
            cfg_r.csreg <= PWDATA[15:8] & CS_MASK;
            cmd_r       <= PWDATA[4:0];
          end
          OFS_CLKDIV: begin
            cfg_r.clk_div       <= PWDATA[7:0];
            cfg_r.clk_div_valid <= 1'b1;
          end
          OFS_CMD:  cfg_r.spi_cmd  <= PWDATA;
          OFS_ADDR: cfg_r.spi_addr <= PWDATA;
          OFS_LEN: begin
            cfg_r.data_len <= PWDATA[31:16];
            cfg_r.addr_len <= PWDATA[13:8];
            cfg_r.cmd_len  <= PWDATA[5:0];
          end
          OFS_DUM: begin
            cfg_r.dummy_wr <= PWDATA[31:16];
            cfg_r.dummy_rd <= PWDATA[15:0];
          end
          OFS_INTCFG: begin
            int_en_r <= PWDATA[31:29];
            th_rx_r  <= PWDATA[15:8];
            th_tx_r  <= PWDATA[7:0];
          end
          default: cmd_r <= 5'b00000;
        endcase
      end else begin
        cmd_r <= 5'b00000;
      end
    end
  end

  // Read mux
  always_comb begin
    PRDATA = 32'h0000_0000;
    case (addr_s)
      OFS_STATUS: PRDATA = status_i;
      OFS_CLKDIV: PRDATA = {24'h00_0000, cfg_r.clk_div};
      OFS_CMD:    PRDATA = cfg_r.spi_cmd;
      OFS_ADDR:   PRDATA = cfg_r.spi_addr;
      OFS_LEN:    PRDATA = {cfg_r.data_len, 2'b00, cfg_r.addr_len, 2'b00, cfg_r.cmd_len};
      OFS_DUM:    PRDATA = {cfg_r.dummy_wr, cfg_r.dummy_rd};
      OFS_RXFIFO: PRDATA = rx_data_i;
      OFS_INTCFG: PRDATA = {int_en_r, 13'h0000, th_rx_r, th_tx_r};
      OFS_INTSTA: PRDATA = {29'h0000_0000, intsta_s};
      default:    PRDATA = 32'h0000_0000;
    endcase
  end

  spi_apb_irq #(
    .LVL_W (LOG_BUFFER_DEPTH + 1)
  ) u_irq (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .tx_lvl_i (tx_lvl_i),
    .rx_lvl_i (rx_lvl_i),
    .th_tx    (th_tx_r),
    .th_rx    (th_rx_r),
    .eot_i    (eot_i),
    .int_en   ({int_en_r[2], int_en_r[1], int_en_r[0]}),
    .clr_en   (reg_wr_s & (addr_s == OFS_INTSTA)),
    .clr_mask (PWDATA[2:0]),
    .intsta   (intsta_s),
    .irq_o    (irq_o)
  );

  assign cfg_o = cfg_r;
  assign cmd_o = cmd_r;

endmodule

// File: tb/tb_spi_master_apb_regif.sv
// Scoreboard bench for spi_master_apb_regif: the driver queues the expected APB completion,
// a negedge monitor checks it when PREADY closes the transfer.
module tb_spi_master_apb_regif;
  import spi_apb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = 12'h000;
  logic [31:0] PWDATA = 32'h0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  spi_cfg_t    cfg_o;
  logic [4:0]  cmd_o;
  logic [31:0] status_i = 32'hCAFE_0001;
  logic [5:0]  tx_lvl_i = 6'd5;
  logic [5:0]  rx_lvl_i = 6'd3;
  logic        eot_i = 1'b0;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [31:0] rx_data_i = 32'h1357_9BDF;
  logic        rx_valid_i = 1'b1;
  logic        rx_ready_o;
  logic        irq_o;

  spi_master_apb_regif dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_o(cfg_o), .cmd_o(cmd_o), .status_i(status_i), .tx_lvl_i(tx_lvl_i), .rx_lvl_i(rx_lvl_i),
    .eot_i(eot_i), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .irq_o(irq_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          waits;
    logic        push;
    logic        pop;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   wait_cnt = 0;
  logic stray = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: count wait states and score each completed transfer
  always @(negedge HCLK) begin
    if (PSEL && PENABLE) begin
      if (!PREADY) begin
        wait_cnt++;
        if (tx_valid_o || rx_ready_o) stray = 1'b1;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: addr 0x%03h with empty scoreboard", PADDR);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pslverr", 32'(PSLVERR), 32'(mon_e.err));
          chk("wait_states", wait_cnt, mon_e.waits);
          chk("tx_valid", 32'(tx_valid_o), 32'(mon_e.push));
          chk("rx_ready", 32'(rx_ready_o), 32'(mon_e.pop));
          chk("handshake_during_stall", 32'(stray), 32'd0);
          if (mon_e.chk_rd) chk("prdata", PRDATA, mon_e.rdata);
          if (mon_e.push)   chk("tx_data", tx_data_o, mon_e.wdata);
        end
        wait_cnt = 0;
        stray    = 1'b0;
      end
    end else begin
      wait_cnt = 0;
      stray    = 1'b0;
    end
  end

  // delay: access cycles before the FIFO becomes ready (0 = ready at once, <0 = never)
  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                     input logic [31:0] rdata, input logic chk_rd, input logic err,
                     input int delay, input int waits, input logic push, input logic pop);
    exp_t e;
    int   n;
    e.rdata = rdata; e.chk_rd = chk_rd; e.err = err; e.waits = waits;
    e.push = push; e.pop = pop; e.wdata = data;
    exp_q.push_back(e);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    if (delay != 0) begin
      tx_ready_i = 1'b0;
      rx_valid_i = 1'b0;
    end
    forever begin
      @(negedge HCLK);
      if (PREADY) break;
      @(posedge HCLK); #1;
      n++;
      if (delay > 0 && n >= delay) begin
        tx_ready_i = 1'b1;
        rx_valid_i = 1'b1;
      end
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL apb_no_pready: addr 0x%03h still stalled after %0d cycles", addr, n);
        break;
      end
    end
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; tx_ready_i = 1'b1; rx_valid_i = 1'b1;
  endtask

  task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data);
    apb(1'b1, addr, data, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic rd_reg(input logic [11:0] addr, input logic [31:0] expv);
    apb(1'b0, addr, 32'h0, expv, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic err_acc(input logic wr, input logic [11:0] addr);
    apb(wr, addr, 32'hFFFF_FFFF, 32'h0, ~wr, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst cfg_o", 32'(|cfg_o), 32'd0);
    chk("rst cmd_o", 32'(cmd_o), 32'd0);
    chk("rst irq_o", 32'(irq_o), 32'd0);
    chk("rst tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst rx_ready", 32'(rx_ready_o), 32'd0);
    chk("rst pready", 32'(PREADY), 32'd1);
    chk("rst pslverr", 32'(PSLVERR), 32'd0);

    wr_reg(12'h010, 32'h0020_0808);
    rd_reg(12'h010, 32'h0020_0808);
    chk("len data_len", 32'(cfg_o.data_len), 32'd32);
    chk("len addr_len", 32'(cfg_o.addr_len), 32'd8);
    chk("len cmd_len", 32'(cfg_o.cmd_len), 32'd8);

    wr_reg(12'h004, 32'h0000_01FF);
    chk("clkdiv value", 32'(cfg_o.clk_div), 32'h0000_00FF);
    chk("clkdiv valid pulse", 32'(cfg_o.clk_div_valid), 32'd1);
    @(posedge HCLK); #1;
    chk("clkdiv valid drop", 32'(cfg_o.clk_div_valid), 32'd0);
    rd_reg(12'h004, 32'h0000_00FF);

    wr_reg(12'h008, 32'h0000_00EB);
    rd_reg(12'h008, 32'h0000_00EB);
    wr_reg(12'h00C, 32'h1234_5678);
    rd_reg(12'h00C, 32'h1234_5678);
    wr_reg(12'h014, 32'hDEAD_BEEF);
    rd_reg(12'h014, 32'hDEAD_BEEF);
    chk("cfg spi_addr", cfg_o.spi_addr, 32'h1234_5678);
    chk("cfg dummy_wr", 32'(cfg_o.dummy_wr), 32'h0000_DEAD);

    wr_reg(12'h000, 32'h0000_FF15);
    chk("cmd pulse", 32'(cmd_o), 32'h0000_0015);
    chk("csreg masked", 32'(cfg_o.csreg), 32'h0000_000F);
    @(posedge HCLK); #1;
    chk("cmd pulse drop", 32'(cmd_o), 32'd0);
    rd_reg(12'h000, 32'hCAFE_0001);
    rd_reg(12'h013, 32'h0020_0808);

    apb(1'b1, 12'h018, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 3, 3, 1'b1, 1'b0);
    apb(1'b1, 12'h018, 32'h1111_2222, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    apb(1'b0, 12'h020, 32'h0, 32'h1357_9BDF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
`ifdef SPI_APB_TIMEOUT_EN
    apb(1'b0, 12'h020, 32'h0, 32'h0, 1'b0, 1'b1, -1, 16, 1'b0, 1'b0);
`else
    apb(1'b0, 12'h020, 32'h0, 32'h1357_9BDF, 1'b1, 1'b0, 20, 20, 1'b0, 1'b1);
`endif

    // Abandoned TX transfer: PSEL drops mid-stall
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h018; PWDATA = 32'h0BAD_0BAD; tx_ready_i = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("abort pready", 32'(PREADY), 32'd0);
      chk("abort no push", 32'(tx_valid_o), 32'd0);
      @(posedge HCLK); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0; tx_ready_i = 1'b1;
    @(negedge HCLK);
    chk("abort after drop", 32'(tx_valid_o), 32'd0);
    apb(1'b1, 12'h018, 32'h3333_4444, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    err_acc(1'b1, 12'h01C);
    chk("err cfg data_len", 32'(cfg_o.data_len), 32'd32);
    chk("err cfg spi_cmd", cfg_o.spi_cmd, 32'h0000_00EB);
    chk("err cfg csreg", 32'(cfg_o.csreg), 32'h0000_000F);
    err_acc(1'b0, 12'h018);
    err_acc(1'b1, 12'h020);
    err_acc(1'b0, 12'h03C);

    rd_reg(12'h028, 32'h0000_0002);
    wr_reg(12'h024, 32'h8000_0800);
    rd_reg(12'h024, 32'h8000_0800);
    wr_reg(12'h028, 32'h0000_0007);
    rd_reg(12'h028, 32'h0000_0000);
    chk("irq idle", 32'(irq_o), 32'd0);
    @(posedge HCLK); #1;
    eot_i = 1'b1;
    @(posedge HCLK); #1;
    eot_i = 1'b0;
    chk("irq lag", 32'(irq_o), 32'd0);
    @(posedge HCLK); #1;
    chk("irq on eot", 32'(irq_o), 32'd1);
    rd_reg(12'h028, 32'h0000_0004);
    wr_reg(12'h028, 32'h0000_0004);
    @(posedge HCLK); #1;
    chk("irq cleared", 32'(irq_o), 32'd0);
    rd_reg(12'h028, 32'h0000_0000);
    eot_i = 1'b1;
    wr_reg(12'h028, 32'h0000_0004);
    eot_i = 1'b0;
    rd_reg(12'h028, 32'h0000_0004);
    chk("irq set wins", 32'(irq_o), 32'd1);
    wr_reg(12'h024, 32'h8000_0808);
    rd_reg(12'h028, 32'h0000_0005);

    repeat (2) @(posedge HCLK);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
